mem_stage_atomic: RTL and testbench

- MEM-stage access sequencer placed directly downstream of the EX/MEM pipeline register; consumes its outputs (dmemren, dmemwen, datomic_mem, dmemaddr, dmemstore).
- Drives the per-core dcache request, holds the LL/SC link register, and resolves SC success or failure.
- Produces the SC result word and the MEM stall that gates the pipeline-register enables.
- Link is cleared by coherence snoop invalidations and by local stores to the linked address.

---
 rtl/mem_stage_atomic.sv | 124 ++++++++++++
 tb/tb_mem_stage_atomic.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_atomic.sv
// MEM-stage access sequencer: issues dcache requests for the EX/MEM access,
// holds the LL/SC link register and resolves SC success or failure.
module mem_stage_atomic #(
    parameter int LINK_LSB = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemren,
    input  logic              dmemwen,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [ADDR_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic              dcache_ren,
    output logic              dcache_wen,
    output logic [ADDR_W-1:0] dcache_addr,
    output logic [ADDR_W-1:0] dcache_store,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] sc_rdat,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic              sc_ok_q, sc_ok_d;

    logic is_ll, is_sc, req, match, snoop_hit, sc_fail;
    logic ren_c, wen_c, stall_c;

    assign is_ll = dmemren & datomic;
    assign is_sc = dmemwen & datomic;
    assign req   = dmemren | dmemwen;

    // Block-granular compares: low LINK_LSB bits are shifted out of the XOR.
    assign match     = ((dmemaddr ^ link_addr_q) >> LINK_LSB) == '0;
    assign snoop_hit = ccinv && (((ccsnoopaddr ^ link_addr_q) >> LINK_LSB) == '0);
    assign sc_fail   = is_sc & ~(link_valid_q & match);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d      = state_q;
        link_valid_d = link_valid_q & ~snoop_hit;
        link_addr_d  = link_addr_q;
        sc_ok_d      = sc_ok_q;
        ren_c        = 1'b0;
        wen_c        = 1'b0;
        stall_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall_c = 1'b1;
                    if (sc_fail) begin
                        sc_ok_d      = 1'b0;
                        link_valid_d = 1'b0;
                        state_d      = DONE;
                    end else begin
                        ren_c   = dmemren;
                        wen_c   = dmemwen;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                ren_c   = dmemren;
                wen_c   = dmemwen;
                // An invalidation of the linked block aborts an in-flight SC before its write lands.
                if (is_sc && snoop_hit) begin
                    wen_c        = 1'b0;
                    sc_ok_d      = 1'b0;
                    link_valid_d = 1'b0;
                    state_d      = DONE;
                end else if (dhit) begin
                    state_d = DONE;
                    if (is_ll) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = dmemaddr;
                    end else if (is_sc) begin
                        sc_ok_d      = 1'b1;
                        link_valid_d = 1'b0;
                    end else if (dmemwen && match) begin
                        link_valid_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            sc_ok_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            sc_ok_q      <= sc_ok_d;
        end
    end

    // Request outputs are forced low while reset is held, even with EX/MEM inputs still present.
    assign dcache_ren   = ren_c & nRST;
    assign dcache_wen   = wen_c & nRST;
    assign mem_stall    = stall_c & nRST;
    assign dcache_addr  = nRST ? dmemaddr : '0;
    assign dcache_store = nRST ? dmemstore : '0;
    assign sc_rdat      = {{(ADDR_W-1){1'b0}}, sc_ok_q};
    assign link_valid   = link_valid_q;
    assign link_addr    = link_addr_q;

endmodule

// File: tb/tb_mem_stage_atomic.sv
// Self-checking bench for mem_stage_atomic: directed vector table, reset
// corner case, then random accesses against a transaction-level model.
module tb_mem_stage_atomic;

    localparam int LINK_LSB = 2;
    localparam int BUDGET   = 40;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemren, dmemwen, datomic, dhit, ccinv;
    logic [31:0] dmemaddr, dmemstore, ccsnoopaddr;
    logic        dcache_ren, dcache_wen, mem_stall, link_valid;
    logic [31:0] dcache_addr, dcache_store, sc_rdat, link_addr;

    mem_stage_atomic #(.LINK_LSB(LINK_LSB), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemren(dmemren), .dmemwen(dmemwen), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dcache_ren(dcache_ren), .dcache_wen(dcache_wen),
        .dcache_addr(dcache_addr), .dcache_store(dcache_store),
        .mem_stall(mem_stall), .sc_rdat(sc_rdat),
        .link_valid(link_valid), .link_addr(link_addr)
    );

    always #5 CLK = ~CLK;

    typedef enum int {OP_NOP, OP_LD, OP_ST, OP_LL, OP_SC} op_e;

    // hd: index of the access cycle carrying dhit (0 = IDLE cycle, -1 = none).
    // sat: index of the cycle carrying ccinv (-1 = none).
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        int          hd;
        int          sat;
        logic [31:0] saddr;
        int          e_stall;
        int          e_req;
        logic        e_sc;
        logic        e_lv;
        logic [31:0] e_la;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        m_lv;
    logic [31:0] m_la;
    logic        m_sc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input op_e op, input logic [31:0] addr, input logic [31:0] data,
                       input int hd, input int sat, input logic [31:0] saddr,
                       input int e_stall, input int e_req, input logic e_sc,
                       input logic e_lv, input logic [31:0] e_la);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.hd = hd; v.sat = sat; v.saddr = saddr;
        v.e_stall = e_stall; v.e_req = e_req; v.e_sc = e_sc; v.e_lv = e_lv; v.e_la = e_la;
        tbl.push_back(v);
    endtask

    function automatic bit same_blk(input logic [31:0] a, input logic [31:0] b);
        return (a >> LINK_LSB) == (b >> LINK_LSB);
    endfunction

    // Architectural LL/SC rules applied to a whole access at once.
    task automatic model_op(input op_e op, input logic [31:0] addr, input int hd, input int sat,
                            input logic [31:0] saddr, output int e_stall, output int e_req);
        bit snoop = (sat >= 0) && same_blk(saddr, m_la);
        e_stall = 0;
        e_req   = 0;
        case (op)
            OP_NOP: if (snoop) m_lv = 1'b0;
            OP_LD: begin
                if (snoop) m_lv = 1'b0;
                e_stall = hd + 1; e_req = hd + 1;
            end
            OP_LL: begin
                m_lv = 1'b1; m_la = addr;
                e_stall = hd + 1; e_req = hd + 1;
            end
            OP_ST: begin
                if (snoop || same_blk(addr, m_la)) m_lv = 1'b0;
                e_stall = hd + 1; e_req = hd + 1;
            end
            OP_SC: begin
                if (!(m_lv && same_blk(addr, m_la))) begin
                    e_stall = 1; m_sc = 1'b0;
                end else if (snoop && sat >= 1) begin
                    e_stall = sat + 1; e_req = sat; m_sc = 1'b0;
                end else begin
                    e_stall = hd + 1; e_req = hd + 1; m_sc = 1'b1;
                end
                m_lv = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        dmemren = 1'b0; dmemwen = 1'b0; datomic = 1'b0;
        dmemaddr = '0; dmemstore = '0; dhit = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0;
    endtask

    // Presents one EX/MEM access and holds it until the stage stops stalling.
    task automatic run_op(input string tag, input op_e op, input logic [31:0] addr,
                          input logic [31:0] data, input int hd, input int sat,
                          input logic [31:0] saddr, output int stall, output int ren,
                          output int wen, output bit ok);
        bit done = 0;
        stall = 0; ren = 0; wen = 0; ok = 1;
        @(negedge CLK);
        dmemren   = (op == OP_LD) || (op == OP_LL);
        dmemwen   = (op == OP_ST) || (op == OP_SC);
        datomic   = (op == OP_LL) || (op == OP_SC);
        dmemaddr  = addr;
        dmemstore = data;
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) @(negedge CLK);
            dhit        = (c == hd);
            ccinv       = (c == sat);
            ccsnoopaddr = saddr;
            #1;
            if (dcache_ren) begin
                ren++;
                if (dcache_addr !== addr) ok = 0;
            end
            if (dcache_wen) begin
                wen++;
                if (dcache_addr !== addr || dcache_store !== data) ok = 0;
            end
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stall++;
        end
        check({tag, "_timeout"}, 32'(done), 32'd1);
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic check_result(input string tag, input op_e op, input int stall, input int ren,
                                input int wen, input bit ok, input int e_stall, input int e_req,
                                input logic e_sc, input logic e_lv, input logic [31:0] e_la);
        bit is_rd = (op == OP_LD) || (op == OP_LL);
        check({tag, "_stall"}, 32'(stall), 32'(e_stall));
        check({tag, "_ren"}, 32'(ren), is_rd ? 32'(e_req) : 32'd0);
        check({tag, "_wen"}, 32'(wen), is_rd ? 32'd0 : 32'(e_req));
        check({tag, "_reqdata"}, 32'(ok), 32'd1);
        check({tag, "_sc_rdat"}, sc_rdat, {31'b0, e_sc});
        check({tag, "_link_valid"}, {31'b0, link_valid}, {31'b0, e_lv});
        check({tag, "_link_addr"}, link_addr, e_la);
    endtask

    initial begin
        int   stall, ren, wen, e_stall, e_req;
        bit   ok;
        op_e  op;
        logic [31:0] addr, data, saddr;
        logic [31:0] pool [4];
        int   hd, sat, r;

        // op, addr, data, hd, sat, saddr | stall, req, sc, link_valid, link_addr
        add(OP_LL,  32'h100, 32'h0,    3, -1, 32'h0,   4, 4, 1'b0, 1'b1, 32'h100);
        add(OP_SC,  32'h100, 32'hDEAD, 2, -1, 32'h0,   3, 3, 1'b1, 1'b0, 32'h100);
        add(OP_SC,  32'h200, 32'h1234, 2, -1, 32'h0,   1, 0, 1'b0, 1'b0, 32'h100);
        add(OP_LL,  32'h100, 32'h0,    1, -1, 32'h0,   2, 2, 1'b0, 1'b1, 32'h100);
        add(OP_NOP, 32'h0,   32'h0,   -1,  0, 32'h100, 0, 0, 1'b0, 1'b0, 32'h100);
        add(OP_SC,  32'h100, 32'h5555, 1, -1, 32'h0,   1, 0, 1'b0, 1'b0, 32'h100);
        add(OP_LL,  32'h100, 32'h0,    2, -1, 32'h0,   3, 3, 1'b0, 1'b1, 32'h100);
        add(OP_NOP, 32'h0,   32'h0,   -1,  0, 32'h104, 0, 0, 1'b0, 1'b1, 32'h100);
        add(OP_SC,  32'h100, 32'hBEEF, 1, -1, 32'h0,   2, 2, 1'b1, 1'b0, 32'h100);
        add(OP_LL,  32'h100, 32'h0,    1, -1, 32'h0,   2, 2, 1'b1, 1'b1, 32'h100);
        add(OP_SC,  32'h100, 32'hCAFE, 4,  2, 32'h100, 3, 2, 1'b0, 1'b0, 32'h100);
        add(OP_LL,  32'h100, 32'h0,    1, -1, 32'h0,   2, 2, 1'b0, 1'b1, 32'h100);
        add(OP_ST,  32'h180, 32'h1111, 2, -1, 32'h0,   3, 3, 1'b0, 1'b1, 32'h100);
        add(OP_ST,  32'h100, 32'h2222, 1, -1, 32'h0,   2, 2, 1'b0, 1'b0, 32'h100);
        add(OP_NOP, 32'h0,   32'h0,    0, -1, 32'h0,   0, 0, 1'b0, 1'b0, 32'h100);
        add(OP_LL,  32'h104, 32'h0,    2,  2, 32'h104, 3, 3, 1'b0, 1'b1, 32'h104);
        add(OP_SC,  32'h104, 32'h7777, 1,  0, 32'h104, 2, 2, 1'b1, 1'b0, 32'h104);
        add(OP_LL,  32'h108, 32'h0,    1, -1, 32'h0,   2, 2, 1'b1, 1'b1, 32'h108);
        add(OP_LD,  32'h300, 32'h0,    2,  1, 32'h108, 3, 3, 1'b1, 1'b0, 32'h108);

        idle_inputs();
        nRST = 1'b0;
        #1;
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_sc_rdat", sc_rdat, 32'd0);
        check("rst_link_valid", {31'b0, link_valid}, 32'd0);
        check("rst_link_addr", link_addr, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) begin
            string tag = $sformatf("v%0d", i);
            run_op(tag, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].hd, tbl[i].sat,
                   tbl[i].saddr, stall, ren, wen, ok);
            check_result(tag, tbl[i].op, stall, ren, wen, ok, tbl[i].e_stall, tbl[i].e_req,
                         tbl[i].e_sc, tbl[i].e_lv, tbl[i].e_la);
        end

        // Reset asserted mid-WAIT of a successful SC.
        run_op("rst_ll", OP_LL, 32'h100, 32'h0, 1, -1, 32'h0, stall, ren, wen, ok);
        check("rst_ll_link", {31'b0, link_valid}, 32'd1);
        @(negedge CLK);
        dmemwen = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hABCD;
        #1;
        check("rst_sc_idle_wen", {31'b0, dcache_wen}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("rst_sc_wait_wen", {31'b0, dcache_wen}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_async_wen", {31'b0, dcache_wen}, 32'd0);
        check("rst_async_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_async_link", {31'b0, link_valid}, 32'd0);
        check("rst_async_sc", sc_rdat, 32'd0);
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("rst_after_wen%0d", c), {31'b0, dcache_wen}, 32'd0);
        end

        m_lv = 1'b0; m_la = '0; m_sc = 1'b0;
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h200;
        for (int i = 0; i < 120; i++) begin
            string tag = $sformatf("rnd%0d", i);
            r = int'($urandom_range(0, 9));
            op = (r < 3) ? OP_LL : (r < 6) ? OP_SC : (r == 6) ? OP_LD : (r < 9) ? OP_ST : OP_NOP;
            addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            saddr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            data  = $urandom;
            if (op == OP_NOP) begin
                hd  = ($urandom_range(0, 1) == 0) ? 0 : -1;
                sat = ($urandom_range(0, 1) == 0) ? 0 : -1;
            end else begin
                hd  = int'($urandom_range(1, 4));
                sat = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, hd));
            end
            model_op(op, addr, hd, sat, saddr, e_stall, e_req);
            run_op(tag, op, addr, data, hd, sat, saddr, stall, ren, wen, ok);
            check_result(tag, op, stall, ren, wen, ok, e_stall, e_req, m_sc, m_lv, m_la);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
